// File: rtl/operand_fetch_wb.sv
// operand_fetch_wb
//  Initiator side of the RegisterFile port set. Takes one micro-op (rd, rs1, rs2, wb)
//  at a time. It reads both source registers and hands the operands to the ALU over
//  valid/ready. It then waits for the ALU result and, when wb=1, writes that result
//  back to the RegisterFile for exactly one cycle.
//
//  Ports
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   uop_valid/uop_ready         decoder handshake; uop_rd/rs1/rs2/wb = micro-op fields
//   rd_addr1/2, rd_data1/2      RegisterFile read ports (combinational read)
//   write_en, wr_addr, wr_data  RegisterFile write port (write on rising edge)
//   op_valid/op_ready, op_a/b   operand handshake to the ALU
//   res_valid, res_data         ALU result (single-cycle pulse)
//   busy                        high whenever the FSM is not IDLE
//
//  Configuration macro: BYPASS_EN
//   When defined, the FETCH state is removed. Operands are read combinationally from
//   uop_rs1/uop_rs2 and captured on the accept edge. A new micro-op can also be
//   accepted during WB; a source that matches the register being written takes
//   wr_data, which forwards the same-edge write.

module operand_fetch_wb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uop_valid,
  output logic              uop_ready,
  input  logic [ADDR_W-1:0] uop_rd,
  input  logic [ADDR_W-1:0] uop_rs1,
  input  logic [ADDR_W-1:0] uop_rs2,
  input  logic              uop_wb,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  output logic              write_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    WB    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              wb_q, wb_d;
  // The read-address registers also hold the latched rs1/rs2 of the current micro-op.
  logic [ADDR_W-1:0] rd_addr1_q, rd_addr1_d;
  logic [ADDR_W-1:0] rd_addr2_q, rd_addr2_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      wb_q       <= 1'b0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wb_q       <= wb_d;
      rd_addr1_q <= rd_addr1_d;
      rd_addr2_q <= rd_addr2_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wb_d       = wb_q;
    rd_addr1_d = rd_addr1_q;
    rd_addr2_d = rd_addr2_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      IDLE: begin
        if (uop_valid) begin
          rd_d       = uop_rd;
          wb_d       = uop_wb;
          rd_addr1_d = uop_rs1;
          rd_addr2_d = uop_rs2;
`ifdef BYPASS_EN
          op_a_d     = rd_data1;
          op_b_d     = rd_data2;
          state_d    = ISSUE;
`else
          state_d    = FETCH;
`endif
        end
      end
      FETCH: begin
        op_a_d  = rd_data1;
        op_b_d  = rd_data2;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (op_ready) begin
          if (res_valid) begin
            // Result arrived on the handshake cycle, so WAIT is skipped.
            if (wb_q) begin
              wr_addr_d = rd_q;
              wr_data_d = res_data;
              state_d   = WB;
            end else begin
              state_d   = IDLE;
            end
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (res_valid) begin
          // wr_addr/wr_data change only when a write follows, so they hold otherwise.
          if (wb_q) begin
            wr_addr_d = rd_q;
            wr_data_d = res_data;
            state_d   = WB;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      WB: begin
        state_d = IDLE;
`ifdef BYPASS_EN
        if (uop_valid) begin
          rd_d       = uop_rd;
          wb_d       = uop_wb;
          rd_addr1_d = uop_rs1;
          rd_addr2_d = uop_rs2;
          // The RegisterFile write lands on this same edge, so a matching source
          // would read stale data. Forward wr_data instead.
          op_a_d     = (uop_rs1 == wr_addr_q) ? wr_data_q : rd_data1;
          op_b_d     = (uop_rs2 == wr_addr_q) ? wr_data_q : rd_data2;
          state_d    = ISSUE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BYPASS_EN
  assign uop_ready = (state_q == IDLE) || (state_q == WB);
  assign rd_addr1  = uop_ready ? uop_rs1 : rd_addr1_q;
  assign rd_addr2  = uop_ready ? uop_rs2 : rd_addr2_q;
`else
  assign uop_ready = (state_q == IDLE);
  assign rd_addr1  = rd_addr1_q;
  assign rd_addr2  = rd_addr2_q;
`endif

  assign op_valid = (state_q == ISSUE);
  assign write_en = (state_q == WB);
  assign busy     = (state_q != IDLE);
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule
